// File: rtl/spill_fill_scheduler.sv
// Spill/fill burst scheduler: arbitrates per-buffer spill and fill requests onto one AXI burst engine.
// Optional SPILL_FILL_STATS_EN adds saturating spill/fill/error counters.
module spill_fill_scheduler #(
  parameter int          NUM_BUFFERS     = 4,
  parameter logic [31:0] SPILL_BASE_ADDR = 32'h1000_0000,
  parameter int          REGION_BEATS    = 4096,
  parameter int          BURST_BEATS     = 16,
  parameter int          BEAT_BYTES      = 8,
  localparam int         IDW             = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NUM_BUFFERS-1:0] spill_req,
  input  logic [NUM_BUFFERS-1:0] fill_req,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic                   cmd_write,
  output logic [IDW-1:0]         cmd_id,
  output logic [31:0]            cmd_addr,
  output logic [7:0]             cmd_len,
  input  logic                   done_valid,
  input  logic                   done_err,
  output logic [NUM_BUFFERS-1:0] spill_done,
  output logic [NUM_BUFFERS-1:0] fill_done,
  output logic [NUM_BUFFERS-1:0] region_full,
  output logic [NUM_BUFFERS-1:0] region_empty,
  output logic [NUM_BUFFERS-1:0] err_sticky,
  output logic                   busy
`ifdef SPILL_FILL_STATS_EN
  ,
  output logic [31:0]            stat_spills,
  output logic [31:0]            stat_fills,
  output logic [15:0]            stat_errors
`endif
);

  localparam int PW  = $clog2(REGION_BEATS);
  localparam int OW  = PW + 1;
  localparam int RSH = $clog2(REGION_BEATS * BEAT_BYTES);
  localparam int BSH = $clog2(BEAT_BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, UPDATE} state_t;

  state_t                 state_q, state_d;
  logic [IDW-1:0]         cur_id_q, cur_id_d;
  logic                   cur_write_q, cur_write_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [31:0]            cmd_addr_q, cmd_addr_d;
  logic                   done_err_q, done_err_d;
  logic [IDW-1:0]         spill_rr_q, spill_rr_d;
  logic [IDW-1:0]         fill_rr_q, fill_rr_d;
  logic [PW-1:0]          wr_ptr_q [NUM_BUFFERS];
  logic [PW-1:0]          wr_ptr_d [NUM_BUFFERS];
  logic [PW-1:0]          rd_ptr_q [NUM_BUFFERS];
  logic [PW-1:0]          rd_ptr_d [NUM_BUFFERS];
  logic [OW-1:0]          occ_q [NUM_BUFFERS];
  logic [OW-1:0]          occ_d [NUM_BUFFERS];
  logic [NUM_BUFFERS-1:0] err_sticky_q, err_sticky_d;
  logic [NUM_BUFFERS-1:0] spill_done_q, spill_done_d;
  logic [NUM_BUFFERS-1:0] fill_done_q, fill_done_d;
  logic [NUM_BUFFERS-1:0] region_full_q, region_full_d;
  logic [NUM_BUFFERS-1:0] region_empty_q, region_empty_d;
`ifdef SPILL_FILL_STATS_EN
  logic [31:0]            stat_spills_q, stat_spills_d;
  logic [31:0]            stat_fills_q, stat_fills_d;
  logic [15:0]            stat_errors_q, stat_errors_d;
`endif

  logic [NUM_BUFFERS-1:0] spill_elig, fill_elig;
  logic [IDW:0]           spill_pick, fill_pick;
  logic [IDW-1:0]         sid, fid;

  // Scan downward so the lowest offset from the pointer is assigned last and wins.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_BUFFERS-1:0] req,
                                           input logic [IDW-1:0] ptr);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_BUFFERS;
      if (req[idx]) res = {1'b1, IDW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (id == IDW'(NUM_BUFFERS - 1)) ? '0 : id + 1'b1;
  endfunction

  function automatic logic [31:0] addr_of(input logic [IDW-1:0] id, input logic [PW-1:0] ptr);
    return SPILL_BASE_ADDR + (32'(id) << RSH) + (32'(ptr) << BSH);
  endfunction

  assign spill_elig = spill_req & ~region_full_q;
  assign fill_elig  = fill_req & ~region_empty_q;
  assign spill_pick = rr_pick(spill_elig, spill_rr_q);
  assign fill_pick  = rr_pick(fill_elig, fill_rr_q);
  assign sid        = spill_pick[IDW-1:0];
  assign fid        = fill_pick[IDW-1:0];

  always_comb begin
    state_d        = state_q;
    cur_id_d       = cur_id_q;
    cur_write_d    = cur_write_q;
    cmd_valid_d    = cmd_valid_q;
    cmd_addr_d     = cmd_addr_q;
    done_err_d     = done_err_q;
    spill_rr_d     = spill_rr_q;
    fill_rr_d      = fill_rr_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    occ_d          = occ_q;
    err_sticky_d   = err_sticky_q;
    spill_done_d   = '0;
    fill_done_d    = '0;
    region_full_d  = '0;
    region_empty_d = '0;
`ifdef SPILL_FILL_STATS_EN
    stat_spills_d  = stat_spills_q;
    stat_fills_d   = stat_fills_q;
    stat_errors_d  = stat_errors_q;
`endif
    case (state_q)
      IDLE: begin
        // Any eligible spill beats any fill so on-chip FIFOs never overflow.
        if (spill_pick[IDW]) begin
          cur_id_d    = sid;
          cur_write_d = 1'b1;
          cmd_addr_d  = addr_of(sid, wr_ptr_q[sid]);
          spill_rr_d  = next_id(sid);
          cmd_valid_d = 1'b1;
          state_d     = ISSUE;
        end else if (fill_pick[IDW]) begin
          cur_id_d    = fid;
          cur_write_d = 1'b0;
          cmd_addr_d  = addr_of(fid, rd_ptr_q[fid]);
          fill_rr_d   = next_id(fid);
          cmd_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (done_valid) begin
          done_err_d = done_err;
          state_d    = UPDATE;
        end
      end
      UPDATE: begin
        // An errored burst leaves the request pending, so arbitration retries it at the same address.
        if (done_err_q) begin
          err_sticky_d[cur_id_q] = 1'b1;
`ifdef SPILL_FILL_STATS_EN
          stat_errors_d = (&stat_errors_q) ? stat_errors_q : stat_errors_q + 16'd1;
`endif
        end else if (cur_write_q) begin
          wr_ptr_d[cur_id_q]     = wr_ptr_q[cur_id_q] + PW'(BURST_BEATS);
          occ_d[cur_id_q]        = occ_q[cur_id_q] + OW'(BURST_BEATS);
          spill_done_d[cur_id_q] = 1'b1;
`ifdef SPILL_FILL_STATS_EN
          stat_spills_d = (&stat_spills_q) ? stat_spills_q : stat_spills_q + 32'd1;
`endif
        end else begin
          rd_ptr_d[cur_id_q]    = rd_ptr_q[cur_id_q] + PW'(BURST_BEATS);
          occ_d[cur_id_q]       = occ_q[cur_id_q] - OW'(BURST_BEATS);
          fill_done_d[cur_id_q] = 1'b1;
`ifdef SPILL_FILL_STATS_EN
          stat_fills_d = (&stat_fills_q) ? stat_fills_q : stat_fills_q + 32'd1;
`endif
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      region_full_d[i]  = (occ_d[i] == OW'(REGION_BEATS));
      region_empty_d[i] = (occ_d[i] == '0);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= IDLE;
      cur_id_q       <= '0;
      cur_write_q    <= 1'b0;
      cmd_valid_q    <= 1'b0;
      cmd_addr_q     <= '0;
      done_err_q     <= 1'b0;
      spill_rr_q     <= '0;
      fill_rr_q      <= '0;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        occ_q[i]    <= '0;
      end
      err_sticky_q   <= '0;
      spill_done_q   <= '0;
      fill_done_q    <= '0;
      region_full_q  <= '0;
      region_empty_q <= '1;
`ifdef SPILL_FILL_STATS_EN
      stat_spills_q  <= '0;
      stat_fills_q   <= '0;
      stat_errors_q  <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cur_id_q       <= cur_id_d;
      cur_write_q    <= cur_write_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_addr_q     <= cmd_addr_d;
      done_err_q     <= done_err_d;
      spill_rr_q     <= spill_rr_d;
      fill_rr_q      <= fill_rr_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      occ_q          <= occ_d;
      err_sticky_q   <= err_sticky_d;
      spill_done_q   <= spill_done_d;
      fill_done_q    <= fill_done_d;
      region_full_q  <= region_full_d;
      region_empty_q <= region_empty_d;
`ifdef SPILL_FILL_STATS_EN
      stat_spills_q  <= stat_spills_d;
      stat_fills_q   <= stat_fills_d;
      stat_errors_q  <= stat_errors_d;
`endif
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_write    = cur_write_q;
  assign cmd_id       = cur_id_q;
  assign cmd_addr     = cmd_addr_q;
  assign cmd_len      = 8'(BURST_BEATS - 1);
  assign spill_done   = spill_done_q;
  assign fill_done    = fill_done_q;
  assign region_full  = region_full_q;
  assign region_empty = region_empty_q;
  assign err_sticky   = err_sticky_q;
  assign busy         = (state_q != IDLE);
`ifdef SPILL_FILL_STATS_EN
  assign stat_spills  = stat_spills_q;
  assign stat_fills   = stat_fills_q;
  assign stat_errors  = stat_errors_q;
`endif

endmodule

// File: doc/spill_fill_scheduler.md
Name: spill_fill_scheduler

Overview:
Arbitrates spill (on-chip FIFO → DDR) and fill (DDR → on-chip FIFO) requests from NUM_BUFFERS buffers onto a single shared AXI burst engine. Each buffer owns a circular DDR region. The scheduler tracks per-buffer write pointer, read pointer and occupancy, and issues one burst command at a time. Sits between the fifo_with_spill instances and the AXI master datapath of the buffer manager.

Parameters:
NUM_BUFFERS, 4, number of requesting buffers (2..8)
SPILL_BASE_ADDR, 32'h10000000, DDR base of the spill area
REGION_BEATS, 4096, per-buffer region size in beats (power of 2)
BURST_BEATS, 16, beats per burst (power of 2, divides REGION_BEATS)
BEAT_BYTES, 8, bytes per AXI beat (64-bit data)

Ports:
aclk  in  1  clock
aresetn  in  1  async active-low reset
spill_req  in  NUM_BUFFERS  level; buffer holds ≥BURST_BEATS entries to evict
fill_req  in  NUM_BUFFERS  level; buffer has room for BURST_BEATS entries
cmd_valid  out  1  burst command valid
cmd_ready  in  1  engine accepts command
cmd_write  out  1  1=spill (AXI write), 0=fill (AXI read)
cmd_id  out  $clog2(NUM_BUFFERS)  target buffer
cmd_addr  out  32  burst start byte address
cmd_len  out  8  AXI len (BURST_BEATS-1)
done_valid  in  1  engine finished current burst (1-cycle pulse)
done_err  in  1  BRESP/RRESP error on that burst; qualified by done_valid
spill_done  out  NUM_BUFFERS  1-cycle completion pulse per buffer
fill_done  out  NUM_BUFFERS  1-cycle completion pulse per buffer
region_full  out  NUM_BUFFERS  occupancy == REGION_BEATS
region_empty  out  NUM_BUFFERS  occupancy == 0
err_sticky  out  NUM_BUFFERS  set on errored burst; cleared only by reset
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, all pointers/occupancies 0, rr pointers 0, cmd_valid 0, cmd_* 0, done pulses 0, err_sticky 0, region_empty all 1, region_full 0, busy 0.
- Eligibility: spill_eligible = spill_req & ~region_full; fill_eligible = fill_req & ~region_empty. Ineligible requests remain pending, are not dropped, and are not acknowledged.
- Priority: any eligible spill beats any fill, which prevents on-chip overflow. Within each class, round-robin with a separate pointer per class. After a grant, that class pointer = granted id + 1 (mod NUM_BUFFERS).
- FSM:
  - IDLE: if any eligible request, latch winner id/type → ISSUE (arbitration is registered; cmd_valid rises 1 cycle after the request is seen).
  - ISSUE: cmd_valid=1 with cmd_* stable. On cmd_valid&cmd_ready → WAIT.
  - WAIT: on done_valid → UPDATE.
  - UPDATE (1 cycle): bookkeeping, done pulse, then → IDLE.
  - Minimum request-to-request turnaround: 4 cycles plus engine latency.
- Address: cmd_addr = SPILL_BASE_ADDR + id*REGION_BEATS*BEAT_BYTES + ptr*BEAT_BYTES. Spill uses wr_ptr[id]; fill uses rd_ptr[id]. Bursts are aligned and never cross a region or 4KB boundary.
- UPDATE without error:
  - Spill: wr_ptr += BURST_BEATS, occ += BURST_BEATS, spill_done[id] pulse.
  - Fill: rd_ptr += BURST_BEATS, occ -= BURST_BEATS, fill_done[id] pulse.
  - Pointers are $clog2(REGION_BEATS) bits and wrap naturally. occ is $clog2(REGION_BEATS)+1 bits.
- UPDATE with done_err: pointers/occ unchanged, err_sticky[id] set, no done pulse. The request stays pending and is retried by normal arbitration.
- region_full/region_empty are registered from occ and update in the UPDATE cycle.
- done_valid outside WAIT is ignored.
- Request deassertion after latch does not cancel the issued command.
- Reset mid-operation: returns to the reset state immediately. In-flight engine commands are the engine's responsibility, since it shares aresetn.

Optional Feature:
SPILL_FILL_STATS_EN. Defined: adds outputs stat_spills (32), stat_fills (32), stat_errors (16). They increment in UPDATE on successful spill, successful fill and errored burst respectively, saturate at max, and reset to 0. Undefined: ports absent, no counters.

Test Plan:
- Reset, then spill_req=4'b0001 held → cmd_valid 1 cycle later, cmd_write=1, cmd_id=0, cmd_addr=0x10000000, cmd_len=15. Engine acks, done → spill_done[0] pulse. Second grant has cmd_addr=0x10000080. region_empty[0]=0.
- spill_req=4'b1111 held, engine always ready → grant order 0,1,2,3,0. Buffer 2 first addr=0x10010000.
- spill_req[1]=1 and fill_req[0]=1 simultaneously with buffer 0 occ=16 → spill to buffer 1 issued first, fill to buffer 0 next at rd addr 0x10000000.
- Fill with region_empty → no command, busy stays 0. 256 spills to buffer 3 → region_full[3]=1, further spill_req[3] ignored. One fill → full clears and rd addr wraps correctly. 256 more fill/spill pairs check pointer wrap to 0x10018000.
- done_err on spill to buffer 2 → err_sticky[2]=1, no spill_done, same cmd_addr reissued on retry.
- Assert aresetn low during WAIT → cmd_valid 0, busy 0, all occ 0 and region_empty all 1 after release. With SPILL_FILL_STATS_EN, counters read 0.
